// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its stream-side consumers.
// Holds the default word width and the pointer-width helper.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Bits needed to index `depth` entries; never less than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream carrying one data word per accepted beat.
// The reader drives it as master; the downstream sink is the slave.
interface fifo_stream_reader_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Circular skid buffer that catches FIFO read data while the stream sink stalls.
// Head data is driven straight from storage, so it holds while no pop occurs.
module fifo_rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BUF_DEPTH  = 2,
    parameter int CW         = ptr_width(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [CW-1:0]         count
);

    localparam int              PW   = ptr_width(BUF_DEPTH);
    localparam logic [PW-1:0]   LAST = PW'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    function automatic logic [PW-1:0] advance(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // NOTE: the storage is reset as well because it feeds the stream data output
    // directly, which must read zero out of reset; it is only a couple of words.
    // NOTE: every register here uses non-blocking assignment so the pointer,
    // count and storage updates all see the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= advance(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= advance(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Turns the FIFO read port (rd_en strobe, dout one cycle later) into a
// valid/ready stream master with a skid buffer absorbing downstream stalls.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    fifo_stream_reader_if.master  m,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  xfer_count
);

    localparam int CW = ptr_width(BUF_DEPTH + 1);

    logic          inflight;
    logic          pop;
    logic          capture;
    logic [CW-1:0] occupancy;
    logic [CW:0]   demand;

    assign pop     = m.valid && m.ready;
    assign capture = inflight && !flush;

    // Slots already spoken for once this cycle's pop leaves; a pop always
    // implies occupancy >= 1, so the subtraction cannot underflow.
    assign demand = {1'b0, occupancy} + (CW + 1)'(inflight) - (CW + 1)'(pop);

    assign fifo_rd_en = enable && !flush && !fifo_empty
                        && (demand < (CW + 1)'(BUF_DEPTH));

    assign m.valid = (occupancy != '0);
    assign busy    = m.valid || inflight;

    // A flush suppresses this cycle's read, so inflight clears on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight   <= 1'b0;
            xfer_count <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (pop) begin
                xfer_count <= xfer_count + 1'b1;
            end
        end
    end

    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH),
        .CW         (CW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (capture),
        .push_data (fifo_dout),
        .pop       (pop),
        .head_data (m.data),
        .count     (occupancy)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader behind a small behavioural FIFO.
// A second instance with a 4-bit counter shares all inputs to exercise counter wrap.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int BD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          flush;
    logic          m_ready;
    logic          fifo_rd_en;
    logic          fifo_rd_en2;
    logic          busy;
    logic          busy2;
    logic [15:0]   xfer_count;
    logic [3:0]    xfer_count2;

    // Behavioural FIFO, depth 8: registered dout, combinational empty.
    logic          f_wr_en;
    logic [DW-1:0] f_din;
    logic [DW-1:0] fmem [8];
    logic [2:0]    fwp;
    logic [2:0]    frp;
    logic [3:0]    fcnt;
    logic [DW-1:0] fdout;
    logic          fifo_empty;

    logic [DW-1:0] exp_q [$];
    int            vectors     = 0;
    int            miscompares = 0;
    int            beat_cnt    = 0;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) s_if ();
    fifo_stream_reader_if #(.DATA_WIDTH(DW)) s2_if ();

    assign s_if.ready  = m_ready;
    assign s2_if.ready = m_ready;
    assign fifo_empty  = (fcnt == 4'd0);

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(BD), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fdout),
        .m          (s_if),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(BD), .CNT_WIDTH(4)) dut_w (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en2),
        .fifo_dout  (fdout),
        .m          (s2_if),
        .busy       (busy2),
        .xfer_count (xfer_count2)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fwp   <= '0;
            frp   <= '0;
            fcnt  <= '0;
            fdout <= '0;
        end else begin
            if (f_wr_en) begin
                fmem[fwp] <= f_din;
                fwp       <= fwp + 1'b1;
            end
            if (fifo_rd_en) begin
                fdout <= fmem[frp];
                frp   <= frp + 1'b1;
            end
            fcnt <= fcnt + 4'(f_wr_en) - 4'(fifo_rd_en);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted beat and watches invariants.
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_rd_en && fifo_empty) begin
                miscompares++;
                $display("FAIL fifo_underflow: rd_en=1 with empty=1 (t=%0t)", $time);
            end
            if (dut.u_buf.count == BD && dut.capture && !dut.pop) begin
                miscompares++;
                $display("FAIL buffer_overflow: write into full buffer (t=%0t)", $time);
            end
            if (s_if.valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL beat: got 0x%0h, expected no beat (t=%0t)", s_if.data, $time);
                end else begin
                    check("beat", 32'(s_if.data), 32'(exp_q.pop_front()));
                end
                beat_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            f_wr_en = 1'b1;
            f_din   = first + DW'(i);
            exp_q.push_back(f_din);
            tick();
        end
        f_wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, 32'(s_if.valid), 32'd0);
        check({tag, "_m_data"}, 32'(s_if.data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_xfer_count"}, 32'(xfer_count), 32'd0);
        check({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        f_wr_en = 1'b0;
        f_din   = '0;
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        #2 rst = 1'b0;
        tick();

        // Streaming: 8 back-to-back reads, beats start two cycles after the first read.
        preload(8'h11, 8);
        tick();
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("stream_rd_en_c%0d", c), 32'(fifo_rd_en), 32'(c < 8));
            check($sformatf("stream_valid_c%0d", c), 32'(s_if.valid), 32'(c >= 2 && c < 10));
            check($sformatf("stream_busy_c%0d", c), 32'(busy), 32'(c >= 1 && c < 10));
            tick();
        end
        check("stream_xfer_count", 32'(xfer_count), 32'd8);
        check("stream_wrap_count", 32'(xfer_count2), 32'd8);

        // Backpressure: exactly two reads fill the buffer; head holds 0x11.
        enable  = 1'b0;
        m_ready = 1'b0;
        preload(8'h11, 8);
        tick();
        enable = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("bp_rd_en_c%0d", c), 32'(fifo_rd_en), 32'(c < 2));
            if (c >= 3) begin
                check($sformatf("bp_valid_c%0d", c), 32'(s_if.valid), 32'd1);
                check($sformatf("bp_hold_c%0d", c), 32'(s_if.data), 32'h11);
            end
            tick();
        end
        m_ready = 1'b1;
        wait_drain("bp_drain", 40);
        tick();
        tick();
        check("bp_xfer_count", 32'(xfer_count), 32'd16);
        check("bp_busy_after", 32'(busy), 32'd0);

        // Empty FIFO and enable low both block reads; an in-flight word still lands.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("empty_rd_en_c%0d", c), 32'(fifo_rd_en), 32'd0);
            tick();
        end
        enable = 1'b0;
        preload(8'h21, 3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("disabled_rd_en_c%0d", c), 32'(fifo_rd_en), 32'd0);
            tick();
        end
        enable = 1'b1;
        @(negedge clk);
        check("enable_pulse_rd_en", 32'(fifo_rd_en), 32'd1);
        tick();
        enable = 1'b0;
        begin
            int n = 0;
            while (exp_q.size() != 2 && n < 20) begin
                tick();
                n++;
            end
        end
        check("inflight_delivered", 32'(exp_q.size()), 32'd2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("disabled2_rd_en_c%0d", c), 32'(fifo_rd_en), 32'd0);
            tick();
        end
        check("enable_xfer_count", 32'(xfer_count), 32'd17);
        enable = 1'b1;
        wait_drain("enable_drain", 20);
        check("enable_xfer_count2", 32'(xfer_count), 32'd19);

        // Flush with 0x11,0x12 buffered: both discarded, stream resumes at 0x13.
        enable  = 1'b0;
        m_ready = 1'b0;
        preload(8'h11, 3);
        enable = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("flush_pre_valid", 32'(s_if.valid), 32'd1);
        check("flush_pre_data", 32'(s_if.data), 32'h11);
        tick();
        flush = 1'b1;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        @(negedge clk);
        check("flush_rd_en", 32'(fifo_rd_en), 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush_valid_after", 32'(s_if.valid), 32'd0);
        check("flush_busy_after", 32'(busy), 32'd0);
        check("flush_xfer_kept", 32'(xfer_count), 32'd19);
        tick();
        m_ready = 1'b1;
        wait_drain("flush_resume", 20);
        check("flush_xfer_count", 32'(xfer_count), 32'd20);
        check("wrap_count_20", 32'(xfer_count2), 32'd4);

        // Reset in the middle of a stream.
        preload(8'h31, 4);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        check("midreset_wrap_count", 32'(xfer_count2), 32'd0);
        exp_q.delete();
        beat_cnt = 0;
        enable   = 1'b0;
        m_ready  = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        tick();

        // Random valid/ready and enable toggling over 1000 words.
        begin
            int written = 0;
            int cyc     = 0;
            while ((written < 1000 || exp_q.size() != 0) && cyc < 30000) begin
                m_ready = ($urandom_range(0, 3) != 0);
                enable  = ($urandom_range(0, 7) != 0);
                if (written < 1000 && fcnt < 4'd8 && $urandom_range(0, 3) != 0) begin
                    f_wr_en = 1'b1;
                    f_din   = DW'($urandom);
                    exp_q.push_back(f_din);
                    written++;
                end else begin
                    f_wr_en = 1'b0;
                end
                tick();
                cyc++;
            end
            f_wr_en = 1'b0;
            check("random_written", 32'(written), 32'd1000);
        end
        check("random_drain", 32'(exp_q.size()), 32'd0);
        check("random_xfer_count", 32'(xfer_count), 32'd1000);
        check("random_wrap_count", 32'(xfer_count2), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side consumer for the team's synchronous FIFO. It converts the FIFO's read port into a valid/ready streaming master:
- FIFO port: rd_en strobe, registered dout one cycle later, combinational empty flag.
- Holds a small skid buffer so downstream backpressure never loses a word.
- Sustains one word per cycle when the downstream is always ready.
- Sits between the FIFO instance and any downstream stream sink (UART TX, packetiser, etc.).

Parameters:
DATA_WIDTH, 8, word width; must match the FIFO's DATA_WIDTH.
BUF_DEPTH, 2, skid buffer entries; must be at least 2, and 2 is sufficient for full throughput.
CNT_WIDTH, 16, width of the transfer counter.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  permits new FIFO reads; already-fetched data still drains when low
flush  in  1  synchronous discard of buffered and in-flight words
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  FIFO read strobe (combinational)
fifo_dout  in  DATA_WIDTH  FIFO registered read data, valid the cycle after fifo_rd_en
m_valid  out  1  stream data valid
m_ready  in  1  stream sink ready
m_data  out  DATA_WIDTH  stream data
busy  out  1  buffer non-empty or read in flight
xfer_count  out  CNT_WIDTH  accepted-beat count

Behaviour:
- Reset (async, rst=1): occupancy=0, inflight=0, pointers=0, xfer_count=0.
  - Outputs m_valid=0, m_data=0, busy=0, fifo_rd_en=0.
  - Any in-flight word is dropped.
- pop = m_valid && m_ready.
- Issue rule: fifo_rd_en = enable && !flush && !fifo_empty && (occupancy + inflight - pop < BUF_DEPTH).
  - This is a combinational path from m_ready, enable, flush and fifo_empty; the remaining terms are registered state.
- inflight <= fifo_rd_en each cycle.
  - When inflight=1 (and no flush), fifo_dout is written at the buffer write pointer on that clock edge.
  - The write pointer advances modulo BUF_DEPTH.
- fifo_dout is ignored in any cycle where inflight=0; the FIFO holds its stale dout in those cycles.
- Latency: rd_en asserted in cycle N, fifo_dout valid in N+1, captured at the end of N+1, m_valid=1 in N+2.
- m_valid = (occupancy != 0). m_data = buffer[rd_ptr], driven from registers.
  - While m_valid && !m_ready, m_data holds stable.
- On pop, rd_ptr advances modulo BUF_DEPTH and xfer_count increments, wrapping at 2^CNT_WIDTH.
- Simultaneous capture and pop: occupancy unchanged.
  - With BUF_DEPTH=2 and m_ready held at 1, the block sustains one beat per cycle.
- Overflow-free: the issue rule guarantees occupancy never exceeds BUF_DEPTH.
  - A write into a full buffer is a design error; the bench flags it with an assertion.
- Never issues a read when fifo_empty=1, so no FIFO underflow.
- enable=0: no new reads; buffered and in-flight words still deliver normally.
- flush=1 (one cycle):
  - fifo_rd_en forced 0.
  - Next cycle: occupancy=0, pointers=0, and a captured in-flight word is discarded.
  - m_valid=0 in the following cycle. xfer_count is not cleared.
  - A pop in the flush cycle itself still counts.
- busy = (occupancy != 0) || inflight.
- Reset mid-stream: immediate return to the reset state; FIFO words already read are lost.

Decomposition:
- Shared fifo_pkg: DATA_WIDTH default constant, and a pointer-width helper (clog2-based) shared with the FIFO.
- One sub-module, fifo_rd_skid_buf: a circular BUF_DEPTH-entry buffer with wr/rd pointers and occupancy.
  - It exposes push, pop, head data, and count.
- The top level holds the issue logic, inflight flag, flush and counter.

Test Plan:
- Reset: assert rst mid-cycle -> m_valid=0, m_data=0, busy=0, xfer_count=0, fifo_rd_en=0 immediately.
- Streaming: the bench instantiates fifo (DEPTH=8), preloaded with 0x11..0x18, enable=1, m_ready=1.
  - fifo_rd_en high 8 consecutive cycles; first m_valid 2 cycles after the first rd_en.
  - Beats 0x11..0x18 back-to-back in order; xfer_count=8; busy drops after the last beat.
- Backpressure: same preload, m_ready=0.
  - Exactly 2 reads, then fifo_rd_en=0; m_data holds 0x11.
  - Release m_ready -> all 8 words delivered in order, none duplicated or lost.
- Empty/enable: fifo_empty=1, or enable=0 with a non-empty FIFO -> fifo_rd_en never asserted.
  - Dropping enable with 1 word in flight -> that word is still delivered.
- Flush: m_ready=0, buffer holding 0x11,0x12, flush pulse.
  - m_valid=0 next cycle; xfer_count unchanged.
  - Subsequent stream resumes with 0x13.
- Wrap: CNT_WIDTH=4, 20 beats -> xfer_count=4.
- Random valid/ready toggling over 1000 words -> scoreboard matches write order exactly.
